// File: rtl/led_pkg.sv
// Shared constants for the LED output path (chaser and fade driver).
package led_pkg;

    localparam int                  NUM_LEDS   = 6;
    localparam int                  PWM_BITS   = 8;
    localparam logic [PWM_BITS-1:0] BRIGHT_MAX = 8'd255;
    localparam logic [PWM_BITS-1:0] PWM_TOP    = 8'd254;
    localparam logic                LED_ON     = 1'b0;

    // Subtract b from a, clamping at zero instead of wrapping.
    function automatic logic [PWM_BITS-1:0] sat_sub(
        input logic [PWM_BITS-1:0] a,
        input logic [PWM_BITS-1:0] b
    );
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness register with set/decay and the PWM compare.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int DECAY_STEP = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                en,
    input  logic                set,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_n_bit
);

    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] r_bright;
    logic [PWM_BITS-1:0] w_bright_next;
    logic                r_led_n;
    logic                w_lit;

    // Brightness priority: disable clears, a commanded LED jumps to full
    // (even on a tick), otherwise a tick fades it toward zero.
    always_comb begin
        w_bright_next = r_bright;
        if (!en) begin
            w_bright_next = '0;
        end else if (set) begin
            w_bright_next = BRIGHT_MAX;
        end else if (tick) begin
            w_bright_next = sat_sub(r_bright, STEP);
        end
    end

    // The counter never reaches 255, so full brightness is lit every cycle.
    assign w_lit = (pwm_cnt < r_bright);

    // Brightness and registered pin drive; reset forces the LED dark at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bright <= '0;
            r_led_n  <= ~LED_ON;
        end else begin
            r_bright <= w_bright_next;
            r_led_n  <= w_lit ? LED_ON : ~LED_ON;
        end
    end

    assign led_n_bit = r_led_n;

endmodule

// File: rtl/led_fade_driver.sv
// PWM output stage for the LED chaser: lit LEDs are full bright, released
// LEDs fade linearly to off, leaving a comet trail.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int DECAY_DIV  = 105_469,
    parameter int DECAY_STEP = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                en,
    input  logic [NUM_LEDS-1:0] pat_n,
    output logic [NUM_LEDS-1:0] led_n
);

    localparam int               PRE_W   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] w_pwm_next;
    logic [PRE_W-1:0]    r_presc;
    logic [PRE_W-1:0]    w_presc_next;
    logic                w_tick;
    logic [NUM_LEDS-1:0] w_led_n;

    assign w_tick = en && (r_presc == PRE_TOP);

    // Both counters sit at zero while disabled so they restart aligned.
    always_comb begin
        w_pwm_next   = r_pwm_cnt + 1'b1;
        w_presc_next = r_presc + 1'b1;
        if (!en) begin
            w_pwm_next   = '0;
            w_presc_next = '0;
        end else begin
            if (r_pwm_cnt == PWM_TOP) begin
                w_pwm_next = '0;
            end
            if (r_presc == PRE_TOP) begin
                w_presc_next = '0;
            end
        end
    end

    // Shared PWM counter and decay prescaler registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pwm_cnt <= '0;
            r_presc   <= '0;
        end else begin
            r_pwm_cnt <= w_pwm_next;
            r_presc   <= w_presc_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
            led_pwm_channel #(
                .DECAY_STEP (DECAY_STEP)
            ) u_chan (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .en        (en),
                .set       (pat_n[gi] == LED_ON),
                .tick      (w_tick),
                .pwm_cnt   (r_pwm_cnt),
                .led_n_bit (w_led_n[gi])
            );
        end
    endgenerate

    assign led_n = w_led_n;

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: three configurations share one stimulus and are
// checked every cycle against an arithmetic model, plus literal spot checks.
module tb_led_fade_driver;

    localparam int CFG_DIV  [3] = '{4, 255, 8};
    localparam int CFG_STEP [3] = '{64, 64, 100};

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       en        = 1'b0;
    logic [5:0] pat_n     = 6'h3F;
    logic [5:0] led_n0, led_n1, led_n2;
    logic [5:0] dut_led [3];

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: cycles since enable, per-channel brightness, expected pins
    int         m_t [3];
    int         m_b [3][6];
    logic [5:0] m_led [3];
    int         q_dec0 [$];

    // Duty measurement on the DIV=255 instance (frames aligned with ticks)
    int lit_cnt [8];
    bit meas_arm = 1'b0;

    always #5 sys_clk = ~sys_clk;

    led_fade_driver #(.DECAY_DIV(4), .DECAY_STEP(64)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .pat_n(pat_n), .led_n(led_n0));
    led_fade_driver #(.DECAY_DIV(255), .DECAY_STEP(64)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .pat_n(pat_n), .led_n(led_n1));
    led_fade_driver #(.DECAY_DIV(8), .DECAY_STEP(100)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .pat_n(pat_n), .led_n(led_n2));

    assign dut_led[0] = led_n0;
    assign dut_led[1] = led_n1;
    assign dut_led[2] = led_n2;

    initial begin
        for (int c = 0; c < 3; c++) begin
            m_t[c]   = 0;
            m_led[c] = 6'h3F;
            for (int i = 0; i < 6; i++) m_b[c][i] = 0;
        end
        for (int f = 0; f < 8; f++) lit_cnt[f] = 0;
    end

    // Behavioural model: pwm = t mod 255, tick when t mod DIV == DIV-1.
    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int c = 0; c < 3; c++) begin
                m_t[c]   = 0;
                m_led[c] = 6'h3F;
                for (int i = 0; i < 6; i++) m_b[c][i] = 0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                int  pwm;
                bit  tk;
                pwm = m_t[c] % 255;
                tk  = en && ((m_t[c] % CFG_DIV[c]) == CFG_DIV[c] - 1);
                for (int i = 0; i < 6; i++) begin
                    m_led[c][i] = (pwm < m_b[c][i]) ? 1'b0 : 1'b1;
                    if (!en) begin
                        m_b[c][i] = 0;
                    end else if (!pat_n[i]) begin
                        m_b[c][i] = 255;
                    end else if (tk) begin
                        if (c == 0 && i == 0 && m_b[c][i] > 0)
                            q_dec0.push_back((m_b[c][i] > CFG_STEP[c]) ? m_b[c][i] - CFG_STEP[c] : 0);
                        m_b[c][i] = (m_b[c][i] > CFG_STEP[c]) ? m_b[c][i] - CFG_STEP[c] : 0;
                    end
                end
                m_t[c] = en ? m_t[c] + 1 : 0;
            end
        end
    end

    // Every-cycle comparison of all pins against the model.
    always @(negedge sys_clk) begin
        for (int c = 0; c < 3; c++) begin
            n_assert++;
            if (dut_led[c] !== m_led[c]) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL led_n dut%0d t=%0t: got %b expected %b", c, $time, dut_led[c], m_led[c]);
            end
        end
    end

    // Count lit cycles of channel 0 per 255-cycle frame on the DIV=255 instance.
    always @(negedge sys_clk) begin
        if (meas_arm && m_t[1] >= 1 && m_t[1] <= 2040 && led_n1[0] == 1'b0)
            lit_cnt[(m_t[1] - 1) / 255]++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    initial begin
        // Test 1: reset, then idle with no commanded LEDs
        repeat (3) @(negedge sys_clk);
        check("reset led_n0", led_n0, 6'h3F);
        check("reset led_n1", led_n1, 6'h3F);
        check("reset led_n2", led_n2, 6'h3F);
        sys_rst_n = 1'b1;
        en        = 1'b1;
        repeat (1000) @(negedge sys_clk);
        check("idle led_n0", led_n0, 6'h3F);
        check("idle led_n2", led_n2, 6'h3F);

        // Test 2: hold LED0 commanded; lit from edge 2
        pat_n = 6'b111110;
        @(negedge sys_clk);
        check("set edge1 led_n0", led_n0, 6'h3F);
        @(negedge sys_clk);
        check("set edge2 led_n0", led_n0, 6'b111110);
        repeat (20) @(negedge sys_clk);
        check("set held led_n0", led_n0, 6'b111110);

        // Test 3: release and measure the fade duty per frame
        en    = 1'b0;
        pat_n = 6'b111110;
        repeat (3) @(negedge sys_clk);
        for (int f = 0; f < 8; f++) lit_cnt[f] = 0;
        meas_arm = 1'b1;
        en       = 1'b1;
        repeat (300) @(negedge sys_clk);
        pat_n = 6'h3F;
        q_dec0.delete();
        repeat (8 * 255 - 300) @(negedge sys_clk);
        check("duty frame1", lit_cnt[1], 255);
        check("duty frame2", lit_cnt[2], 191);
        check("duty frame3", lit_cnt[3], 127);
        check("duty frame4", lit_cnt[4], 63);
        check("duty frame5", lit_cnt[5], 0);
        check("duty frame6", lit_cnt[6], 0);
        meas_arm = 1'b0;
        check("decay steps", q_dec0.size(), 4);
        if (q_dec0.size() == 4) begin
            check("decay b1", q_dec0[0], 191);
            check("decay b2", q_dec0[1], 127);
            check("decay b3", q_dec0[2], 63);
            check("decay b4", q_dec0[3], 0);
        end

        // Test 4: set on LED2 coincides with a tick while b=127
        en    = 1'b0;
        pat_n = 6'h3F;
        repeat (3) @(negedge sys_clk);
        en    = 1'b1;
        pat_n = 6'b111011;
        @(negedge sys_clk);
        pat_n = 6'h3F;
        repeat (10) @(negedge sys_clk);
        check("pre-collision b2", m_b[0][2], 127);
        pat_n = 6'b111011;
        @(negedge sys_clk);
        pat_n = 6'h3F;
        check("collision b2", m_b[0][2], 255);
        repeat (6) @(negedge sys_clk);
        check("collision led_n0[2]", led_n0[2], 0);

        // Test 5: drop enable mid-fade, then re-enable with LED1 commanded
        en    = 1'b0;
        repeat (3) @(negedge sys_clk);
        en    = 1'b1;
        pat_n = 6'b111110;
        @(negedge sys_clk);
        pat_n = 6'h3F;
        repeat (8) @(negedge sys_clk);
        check("mid-fade b0", m_b[0][0], 127);
        en = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("en off led_n0", led_n0, 6'h3F);
        check("en off led_n1", led_n1, 6'h3F);
        check("en off led_n2", led_n2, 6'h3F);
        check("en off b0", m_b[0][0], 0);
        en    = 1'b1;
        pat_n = 6'b111101;
        repeat (2) @(negedge sys_clk);
        check("re-enable led_n0", led_n0, 6'b111101);
        pat_n = 6'h3F;
        repeat (3) @(negedge sys_clk);
        check("pre-reset led_n0", led_n0, 6'b111101);

        // Asynchronous reset assertion between clock edges
        #2 sys_rst_n = 1'b0;
        #1;
        check("async reset led_n0", led_n0, 6'h3F);
        check("async reset led_n1", led_n1, 6'h3F);
        check("async reset led_n2", led_n2, 6'h3F);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Test 6: chaser rotating every 8 cycles on the STEP=100 instance
        pat_n = 6'b111110;
        for (int m = 1; m <= 30; m++) begin
            repeat (8) @(negedge sys_clk);
            if (m >= 5) begin
                check($sformatf("trail head m=%0d", m), m_b[2][(m + 5) % 6], 255);
                check($sformatf("trail -1 m=%0d", m),   m_b[2][(m + 4) % 6], 155);
                check($sformatf("trail -2 m=%0d", m),   m_b[2][(m + 3) % 6], 55);
                check($sformatf("trail -3 m=%0d", m),   m_b[2][(m + 2) % 6], 0);
                check($sformatf("trail -4 m=%0d", m),   m_b[2][(m + 1) % 6], 0);
            end
            pat_n = ~(6'b000001 << (m % 6));
        end
        pat_n = 6'h3F;
        repeat (40) @(negedge sys_clk);
        check("trail faded led_n2", led_n2, 6'h3F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
